gate_manager: RTL and testbench
===============================

GATE_MANAGER -- requirements
Module: gate_manager

Interface
REQ-001 The module SHALL have parameter NUM_SLOTS, default 10, giving the number of gate positions on the map (indices 0..NUM_SLOTS-1).
REQ-002 The module SHALL have parameter LIFETIME, default 5, giving the number of enableDC ticks a placed gate stays up (range 1..7).
REQ-003 The module SHALL have parameter MAX_GATES, default 3, giving the maximum number of simultaneously active gates.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enableDC  input  1  one-cycle tick from the shared rate divider; advances gate lifetimes.
REQ-007 placeReq  input  1  level request to place a gate; driven by the gate-cooldown trigger path.
REQ-008 ability  input  1  gate-ability availability flag from the cooldown block; 1 = placement allowed.
REQ-009 gateLoc  input  4  selected slot index from the gate selector.
REQ-010 playerLoc  input  4  slot index currently occupied by the player character.
REQ-011 gateMap  output  NUM_SLOTS  bit i = 1 when a gate is active in slot i.
REQ-012 placeAck  output  1  one-cycle pulse when a placement is committed.
REQ-013 placeReject  output  1  one-cycle pulse when a placement is refused.
REQ-014 activeCount  output  4  number of set bits in gateMap.
REQ-015 canBuild  output  1  1 when activeCount < MAX_GATES; feeds the gate selector.

Function
REQ-016 The FSM SHALL have the states IDLE, CHECK, RESP and RELEASE.
REQ-017 In IDLE with placeReq=1, the module SHALL latch gateLoc and playerLoc and move to CHECK on the next edge.
REQ-018 In CHECK, the module SHALL evaluate the latched request against current state for one cycle, then move to RESP.
REQ-019 A request SHALL be rejected if any of these holds: ability=0, latched gateLoc >= NUM_SLOTS, gateMap[gateLoc]=1, gateLoc = playerLoc, or activeCount = MAX_GATES.
REQ-020 On accept, the module SHALL, in the RESP cycle, set gateMap[gateLoc], load that slot's lifetime counter with LIFETIME, and pulse placeAck.
REQ-021 On reject, the module SHALL pulse placeReject in the RESP cycle and leave all slot state unchanged.
REQ-022 placeAck and placeReject SHALL be mutually exclusive, each high for exactly one cycle, two cycles after placeReq is first sampled high in IDLE.
REQ-023 The FSM SHALL go from RESP to RELEASE, then stay in RELEASE until placeReq=0, then return to IDLE; a held request therefore produces exactly one response.
REQ-024 Each slot SHALL have its own 3-bit lifetime counter.
REQ-025 On each enableDC tick, every active slot's counter SHALL decrement by 1; the slot whose counter goes from 1 to 0 SHALL clear its gateMap bit on the same edge.
REQ-026 A gate SHALL therefore remain visible for exactly LIFETIME enableDC ticks after commit.
REQ-027 If a commit and an enableDC tick coincide, the newly committed slot SHALL load LIFETIME and not decrement on that edge; all other active slots SHALL decrement normally.
REQ-028 CHECK SHALL use gateMap and activeCount as registered at that cycle.
REQ-029 A slot that expires on the same edge as CHECK SHALL still count as occupied for that request.
REQ-030 activeCount and canBuild SHALL be registered and consistent with gateMap in the same cycle.
REQ-031 placeReq pulses arriving while the FSM is in CHECK, RESP or RELEASE SHALL be ignored.
REQ-032 enableDC SHALL have no effect on the FSM.

Reset
REQ-033 With reset=1 at a clock edge: FSM to IDLE, gateMap=0, all lifetime counters=0, activeCount=0, canBuild=1, placeAck=0, placeReject=0.
REQ-034 Reset SHALL take priority over all other inputs, including a request mid-handshake; no pending ack or reject pulse SHALL appear after reset.

Verification
REQ-035 Basic accept: reset, ability=1, gateLoc=4, playerLoc=0, placeReq high for 1 cycle -> placeAck pulses 2 cycles later, gateMap=0x010, activeCount=1.
REQ-036 Expiry: after REQ-035, apply 5 enableDC ticks -> gateMap[4] stays 1 through tick 4 and clears on tick 5; activeCount=0.
REQ-037 Rejects: ability=0 -> placeReject; gateLoc=playerLoc=3 -> placeReject; gateLoc=12 -> placeReject; gateLoc=4 while slot 4 is active -> placeReject; gateMap unchanged in every case.
REQ-038 Capacity: place gates in slots 1, 2 and 3 -> canBuild=0; a request for slot 5 -> placeReject; one tick expiring slot 1 -> canBuild=1, and a retry for slot 5 -> placeAck.
REQ-039 Held request and collision: placeReq held high for 20 cycles -> exactly one placeAck; a commit coinciding with an enableDC tick -> the new slot shows counter 5 while existing slots decrement.
REQ-040 Reset mid-operation: assert reset during CHECK with 2 gates active -> no ack or reject pulse, gateMap=0, canBuild=1 on the next cycle.

Source files
------------

// File: rtl/gate_manager.sv
// Gate placement manager: a request handshake FSM in front of a bank of
// per-slot lifetime counters that age on the shared enableDC tick.

module gate_slot #(
    parameter int LIFETIME = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    output logic active,
    output logic activeNext
);
    logic [2:0] life;
    logic [2:0] lifeNext;

    // A fresh commit wins over a coincident tick so the new gate gets its full lifetime.
    always_comb begin
        lifeNext = life;
        if (load)
            lifeNext = 3'(LIFETIME);
        else if (tick && life != 3'd0)
            lifeNext = life - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            life <= 3'd0;
        else
            life <= lifeNext;
    end

    assign active     = (life != 3'd0);
    assign activeNext = (lifeNext != 3'd0);
endmodule

module gate_manager #(
    parameter int NUM_SLOTS = 10,
    parameter int LIFETIME  = 5,
    parameter int MAX_GATES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enableDC,
    input  logic                 placeReq,
    input  logic                 ability,
    input  logic [3:0]           gateLoc,
    input  logic [3:0]           playerLoc,
    output logic [NUM_SLOTS-1:0] gateMap,
    output logic                 placeAck,
    output logic                 placeReject,
    output logic [3:0]           activeCount,
    output logic                 canBuild
);
    typedef enum logic [1:0] {IDLE, CHECK, RESP, RELEASE} state_t;

    state_t               state;
    logic [3:0]           locQ;
    logic [3:0]           playerQ;
    logic [NUM_SLOTS-1:0] selOH;
    logic [NUM_SLOTS-1:0] loadVec;
    logic [NUM_SLOTS-1:0] nextMap;
    logic [3:0]           nextCount;
    logic                 occupied;
    logic                 accept;
    logic                 commit;

    always_comb begin
        selOH = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            selOH[i] = (32'(locQ) == i);
    end

    // Decision uses the registered map/count, so a slot expiring on the commit edge still blocks.
    assign occupied = |(gateMap & selOH);
    assign accept   = ability && (32'(locQ) < NUM_SLOTS) && !occupied &&
                      (locQ != playerQ) && (activeCount != 4'(MAX_GATES));
    assign commit   = (state == CHECK) && accept;
    assign loadVec  = selOH & {NUM_SLOTS{commit}};

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        gate_slot #(.LIFETIME(LIFETIME)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .tick       (enableDC),
            .load       (loadVec[g]),
            .active     (gateMap[g]),
            .activeNext (nextMap[g])
        );
    end

    always_comb begin
        nextCount = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            nextCount = nextCount + 4'(nextMap[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            locQ        <= 4'd0;
            playerQ     <= 4'd0;
            placeAck    <= 1'b0;
            placeReject <= 1'b0;
            activeCount <= 4'd0;
            canBuild    <= 1'b1;
        end else begin
            placeAck    <= 1'b0;
            placeReject <= 1'b0;
            activeCount <= nextCount;
            canBuild    <= (nextCount < 4'(MAX_GATES));
            case (state)
                IDLE: begin
                    if (placeReq) begin
                        locQ    <= gateLoc;
                        playerQ <= playerLoc;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    placeAck    <= accept;
                    placeReject <= !accept;
                    state       <= RESP;
                end
                RESP:    state <= RELEASE;
                RELEASE: if (!placeReq) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_manager.sv
// Randomized and directed bench for gate_manager against a slot-lifetime model.

module tb_gate_manager;
    localparam int N  = 10;
    localparam int LT = 5;
    localparam int MG = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enableDC = 1'b0;
    logic         placeReq = 1'b0;
    logic         ability = 1'b0;
    logic [3:0]   gateLoc = 4'd0;
    logic [3:0]   playerLoc = 4'd0;
    logic [N-1:0] gateMap;
    logic         placeAck;
    logic         placeReject;
    logic [3:0]   activeCount;
    logic         canBuild;

    gate_manager #(.NUM_SLOTS(N), .LIFETIME(LT), .MAX_GATES(MG)) dut (
        .clk         (clk),
        .reset       (reset),
        .enableDC    (enableDC),
        .placeReq    (placeReq),
        .ability     (ability),
        .gateLoc     (gateLoc),
        .playerLoc   (playerLoc),
        .gateMap     (gateMap),
        .placeAck    (placeAck),
        .placeReject (placeReject),
        .activeCount (activeCount),
        .canBuild    (canBuild)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Model: remaining ticks per slot, plus where we are in the request handshake.
    int  mLife[N];
    int  mPhase = 0;   // 0 waiting, 1 evaluating, 2 responding, 3 waiting for release
    int  mLoc, mPly, mCnt;
    bit  mAck, mRej, mAcc, mOcc, started = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mLife[i] = 0;
            mPhase = 0; mAck = 0; mRej = 0; started = 1;
        end else begin
            mAck = 0; mRej = 0; mAcc = 0;
            if (mPhase == 1) begin
                mCnt = 0;
                for (int i = 0; i < N; i++) if (mLife[i] > 0) mCnt++;
                mOcc = (mLoc < N) ? (mLife[mLoc] > 0) : 1'b0;
                mAcc = ability && (mLoc < N) && !mOcc && (mLoc != mPly) && (mCnt != MG);
                mAck = mAcc; mRej = !mAcc;
            end
            for (int i = 0; i < N; i++) if (enableDC && mLife[i] > 0) mLife[i]--;
            if (mAcc) mLife[mLoc] = LT;
            case (mPhase)
                0: if (placeReq) begin mLoc = int'(gateLoc); mPly = int'(playerLoc); mPhase = 1; end
                1: mPhase = 2;
                2: mPhase = 3;
                default: if (!placeReq) mPhase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int expMap, expCnt;
            expMap = 0; expCnt = 0;
            for (int i = 0; i < N; i++) if (mLife[i] > 0) begin expMap |= (1 << i); expCnt++; end
            chk("gateMap", int'(gateMap), expMap);
            chk("activeCount", int'(activeCount), expCnt);
            chk("canBuild", int'(canBuild), int'(expCnt < MG));
            chk("placeAck", int'(placeAck), int'(mAck));
            chk("placeReject", int'(placeReject), int'(mRej));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        enableDC = 1'b1; step(); enableDC = 1'b0;
    endtask

    task automatic req(input int loc, input int ply, input bit ab, input bit expAck,
                       input bit tickAtCommit, input string nm);
        gateLoc = 4'(loc); playerLoc = 4'(ply); ability = ab; placeReq = 1'b1;
        step();
        placeReq = 1'b0;
        if (tickAtCommit) enableDC = 1'b1;
        step();
        enableDC = 1'b0;
        chk({nm, "_ack"}, int'(placeAck), int'(expAck));
        chk({nm, "_rej"}, int'(placeReject), int'(!expAck));
        step(); step();
    endtask

    task automatic doReset();
        reset = 1'b1; step(); step(); reset = 1'b0;
    endtask

    initial begin
        int acks;
        step(); step();
        chk("rst_map", int'(gateMap), 0);
        chk("rst_cnt", int'(activeCount), 0);
        chk("rst_canBuild", int'(canBuild), 1);
        reset = 1'b0;

        req(4, 0, 1, 1, 0, "basic");
        chk("basic_map", int'(gateMap), 'h010);
        chk("basic_cnt", int'(activeCount), 1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk("expiry_hold", int'(gateMap[4]), 1);
        end
        tick();
        chk("expiry_map", int'(gateMap), 0);
        chk("expiry_cnt", int'(activeCount), 0);

        req(3, 3, 1, 0, 0, "rej_player");
        req(5, 0, 0, 0, 0, "rej_ability");
        req(12, 0, 1, 0, 0, "rej_range");
        chk("rej_map_empty", int'(gateMap), 0);
        req(4, 0, 1, 1, 0, "place4");
        req(4, 0, 1, 0, 0, "rej_occupied");
        chk("rej_map_kept", int'(gateMap), 'h010);
        doReset();

        req(1, 0, 1, 1, 0, "cap1");
        for (int t = 0; t < 4; t++) tick();
        req(2, 0, 1, 1, 0, "cap2");
        req(3, 0, 1, 1, 0, "cap3");
        chk("cap_full_map", int'(gateMap), 'h00E);
        chk("cap_full_canBuild", int'(canBuild), 0);
        req(5, 0, 1, 0, 0, "cap_rej5");
        tick();
        chk("cap_freed_map", int'(gateMap), 'h00C);
        chk("cap_freed_canBuild", int'(canBuild), 1);
        req(5, 0, 1, 1, 0, "cap_retry5");
        chk("cap_retry_map", int'(gateMap), 'h02C);
        doReset();

        gateLoc = 4'd6; playerLoc = 4'd0; ability = 1'b1; placeReq = 1'b1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin step(); acks += int'(placeAck); end
        placeReq = 1'b0;
        for (int c = 0; c < 4; c++) begin step(); acks += int'(placeAck); end
        chk("held_one_ack", acks, 1);
        tick();
        req(7, 0, 1, 1, 1, "collide");
        for (int t = 0; t < 3; t++) tick();
        chk("collide_old_gone", int'(gateMap), 'h080);
        tick();
        chk("collide_new_kept", int'(gateMap), 'h080);
        tick();
        chk("collide_new_gone", int'(gateMap), 0);
        doReset();

        req(1, 0, 1, 1, 0, "mid1");
        req(2, 0, 1, 1, 0, "mid2");
        gateLoc = 4'd3; placeReq = 1'b1;
        step();
        placeReq = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_ack", int'(placeAck), 0);
        chk("mid_rej", int'(placeReject), 0);
        chk("mid_map", int'(gateMap), 0);
        chk("mid_canBuild", int'(canBuild), 1);
        step(); step();
        chk("mid_no_late_ack", int'(placeAck | placeReject), 0);

        for (int c = 0; c < 600; c++) begin
            placeReq  = ($urandom_range(0, 99) < 35);
            enableDC  = ($urandom_range(0, 99) < 30);
            ability   = ($urandom_range(0, 99) < 85);
            gateLoc   = 4'($urandom_range(0, 15));
            playerLoc = 4'($urandom_range(0, 9));
            reset     = ($urandom_range(0, 99) < 2);
            step();
        end
        reset = 1'b0; placeReq = 1'b0; enableDC = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
